// File: rtl/hasti_uart_fifo_pkg.sv
// Shared definitions for the HASTI UART: bus widths, register map, status/ctrl
// bit indices, FSM encoding and the byte-lane helper.
package hasti_uart_fifo_pkg;

    localparam int unsigned HASTI_ADDR_WIDTH  = 32;
    localparam int unsigned HASTI_BUS_WIDTH   = 32;
    localparam int unsigned HASTI_SIZE_WIDTH  = 3;
    localparam int unsigned HASTI_BURST_WIDTH = 3;
    localparam int unsigned HASTI_PROT_WIDTH  = 4;
    localparam int unsigned DIV_W             = 16;
    localparam int unsigned STATUS_W          = 7;

    localparam logic [1:0] REG_BAUD   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned ST_RXE    = 0;
    localparam int unsigned ST_TXF    = 1;
    localparam int unsigned ST_RXF    = 2;
    localparam int unsigned ST_TXIDLE = 3;
    localparam int unsigned ST_OVR    = 4;
    localparam int unsigned ST_FE     = 5;
    localparam int unsigned ST_PE     = 6;

    localparam int unsigned CT_RXIE = 0;
    localparam int unsigned CT_TXIE = 1;
    localparam int unsigned CT_PEN  = 2;
    localparam int unsigned CT_PODD = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Registered address-phase request.
    typedef struct packed {
        logic [1:0] reg_sel;
        logic       rd;
        logic       wr;
        logic [3:0] lanes;
    } bus_req_t;

    function automatic logic [3:0] lane_mask(input logic [HASTI_SIZE_WIDTH-1:0] size,
                                             input logic [1:0] off);
        case (size)
            3'd0:    lane_mask = 4'b0001 << off;
            3'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hasti_uart_fifo.sv
// HASTI slave UART with RX/TX FIFOs, 16x oversampling baud prescaler and level irq.
// Parity support is compiled in when UART_HASTI_PARITY_EN is defined.
module hasti_uart_fifo
    import hasti_uart_fifo_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter logic [DIV_W-1:0]  RESET_DIV  = 16'd0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [HASTI_ADDR_WIDTH-1:0]  addr,
    input  logic                         read,
    input  logic                         write,
    input  logic [HASTI_SIZE_WIDTH-1:0]  size,
    input  logic [HASTI_BURST_WIDTH-1:0] burst,
    input  logic                         mastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]  prot,
    input  logic [HASTI_BUS_WIDTH-1:0]   wdata,
    output logic [HASTI_BUS_WIDTH-1:0]   rdata,
    output logic                         ready,
    output logic                         resp,
    output logic                         irq,
    input  logic                         RXD,
    output logic                         TXD
);
`ifdef UART_HASTI_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    bus_req_t          req_q;
    logic [DIV_W-1:0]  div_q, pre_cnt;
    logic              tick;
    logic              rxie, txie, pen_q, podd_q, par_on;
    logic              ovr, fe, pe, irq_nx;
    logic              wr_baud, wr_status, wr_ctrl, wr_data, rd_data;
    logic [STATUS_W-1:0] status;
    logic              tx_full, tx_empty, rx_full, rx_empty, rx_pop, txidle;
    logic [7:0]        tx_dout, rx_dout;
    logic              unused_bits;

    assign ready       = 1'b1;
    assign resp        = 1'b0;
    assign unused_bits = ^{burst, mastlock, prot, addr[HASTI_ADDR_WIDTH-1:4],
                           wdata[HASTI_BUS_WIDTH-1:16], req_q.lanes[3:2]};

    assign wr_baud   = req_q.wr & (req_q.reg_sel == REG_BAUD);
    assign wr_status = req_q.wr & (req_q.reg_sel == REG_STATUS) & req_q.lanes[0];
    assign wr_ctrl   = req_q.wr & (req_q.reg_sel == REG_CTRL)   & req_q.lanes[0];
    assign wr_data   = req_q.wr & (req_q.reg_sel == REG_DATA)   & req_q.lanes[0];
    assign rd_data   = req_q.rd & (req_q.reg_sel == REG_DATA);
    assign rx_pop    = rd_data & ~rx_empty;
    assign par_on    = PAR_EN & pen_q;
    assign tick      = (pre_cnt == div_q);

    // ---------------- TX / RX signals ----------------
    uart_state_e tx_state, tx_state_nx, rx_state, rx_state_nx;
    logic [7:0]  tx_shift, tx_shift_nx, rx_shift, rx_shift_nx;
    logic [3:0]  tx_tick_cnt, tx_tick_nx, rx_tick_cnt, rx_tick_nx;
    logic [2:0]  tx_bit_cnt, tx_bit_nx, rx_bit_cnt, rx_bit_nx;
    logic        tx_par, tx_par_nx, tx_pop, txd_nx, tx_bit_end;
    logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_sample, rx_bit_end;
    logic        rx_done, rx_push_q, fe_set, pe_set;

    assign txidle = tx_empty & (tx_state == S_IDLE);
    assign status = {pe, fe, ovr, txidle, rx_full, tx_full, rx_empty};
    assign irq_nx = (rxie & ~rx_empty) | (txie & txidle);

    // Data-phase read mux driven from the registered address.
    always_comb begin
        rdata = '0;
        if (req_q.rd) begin
            case (req_q.reg_sel)
                REG_BAUD:   rdata = HASTI_BUS_WIDTH'(div_q);
                REG_STATUS: rdata = HASTI_BUS_WIDTH'(status);
                REG_DATA:   rdata = rx_empty ? '0 : HASTI_BUS_WIDTH'(rx_dout);
                default:    rdata = HASTI_BUS_WIDTH'({podd_q, pen_q, txie, rxie});
            endcase
        end
    end

    // Bus registers, prescaler, sticky flags, synchroniser and irq.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q     <= '0;
            div_q     <= RESET_DIV;
            pre_cnt   <= '0;
            rxie      <= 1'b0;
            txie      <= 1'b0;
            pen_q     <= 1'b0;
            podd_q    <= 1'b0;
            ovr       <= 1'b0;
            fe        <= 1'b0;
            pe        <= 1'b0;
            irq       <= 1'b0;
            rx_push_q <= 1'b0;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
        end else begin
            req_q     <= '{reg_sel: addr[3:2], rd: read, wr: write,
                           lanes: lane_mask(size, addr[1:0])};
            rx_s1     <= RXD;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            rx_push_q <= rx_done;
            irq       <= irq_nx;
            if (wr_baud) begin
                if (req_q.lanes[0]) div_q[7:0]  <= wdata[7:0];
                if (req_q.lanes[1]) div_q[15:8] <= wdata[15:8];
                pre_cnt <= '0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
            end
            if (wr_ctrl) begin
                rxie <= wdata[CT_RXIE];
                txie <= wdata[CT_TXIE];
                if (PAR_EN) begin
                    pen_q  <= wdata[CT_PEN];
                    podd_q <= wdata[CT_PODD];
                end
            end
            ovr <= (ovr & ~(wr_status & wdata[ST_OVR])) | (rx_push_q & rx_full & ~rx_pop);
            fe  <= (fe  & ~(wr_status & wdata[ST_FE]))  | fe_set;
            if (PAR_EN) pe <= (pe & ~(wr_status & wdata[ST_PE])) | pe_set;
        end
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .resetn(resetn),
        .push(wr_data & ~tx_full), .push_data(wdata[7:0]),
        .pop(tx_pop), .pop_data(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .resetn(resetn),
        .push(rx_push_q), .push_data(rx_shift),
        .pop(rx_pop), .pop_data(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- TX FSM ----------------
    assign tx_bit_end = tick & (tx_tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state    <= S_IDLE;
            tx_shift    <= '0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_par      <= 1'b0;
            TXD         <= 1'b1;
        end else begin
            tx_state    <= tx_state_nx;
            tx_shift    <= tx_shift_nx;
            tx_tick_cnt <= tx_tick_nx;
            tx_bit_cnt  <= tx_bit_nx;
            tx_par      <= tx_par_nx;
            TXD         <= txd_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_pop      = 1'b0;
        case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_state_nx = S_START;
                tx_pop      = 1'b1;
            end
            S_START:  if (tx_bit_end) tx_state_nx = S_DATA;
            S_DATA:   if (tx_bit_end && tx_bit_cnt == 3'd7)
                          tx_state_nx = par_on ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_state_nx = S_STOP;
            S_STOP: if (tx_bit_end) begin
                // Back-to-back frames: next START follows the stop bit directly.
                tx_state_nx = tx_empty ? S_IDLE : S_START;
                tx_pop      = ~tx_empty;
            end
            default: tx_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx_shift_nx = tx_shift;
        tx_tick_nx  = tx_tick_cnt;
        tx_bit_nx   = tx_bit_cnt;
        tx_par_nx   = tx_par;
        if (tx_pop) begin
            tx_shift_nx = tx_dout;
            tx_tick_nx  = '0;
            tx_bit_nx   = '0;
            tx_par_nx   = ^tx_dout ^ podd_q;
        end else if (tick) begin
            tx_tick_nx = tx_tick_cnt + 4'd1;
            if (tx_bit_end && tx_state == S_DATA) begin
                tx_shift_nx = tx_shift >> 1;
                tx_bit_nx   = tx_bit_cnt + 3'd1;
            end
        end
        case (tx_state_nx)
            S_START:  txd_nx = 1'b0;
            S_DATA:   txd_nx = tx_shift_nx[0];
            S_PARITY: txd_nx = tx_par_nx;
            default:  txd_nx = 1'b1;
        endcase
    end

    // ---------------- RX FSM ----------------
    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_sample  = tick & (rx_tick_cnt == 4'd7);
    assign rx_bit_end = tick & (rx_tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_state    <= S_IDLE;
            rx_shift    <= '0;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
        end else begin
            rx_state    <= rx_state_nx;
            rx_shift    <= rx_shift_nx;
            rx_tick_cnt <= rx_tick_nx;
            rx_bit_cnt  <= rx_bit_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_state_nx = S_START;
            S_START:  if (rx_sample && rx_s2) rx_state_nx = S_IDLE;
                      else if (rx_bit_end) rx_state_nx = S_DATA;
            S_DATA:   if (rx_bit_end && rx_bit_cnt == 3'd7)
                          rx_state_nx = par_on ? S_PARITY : S_STOP;
            S_PARITY: if (rx_bit_end) rx_state_nx = S_STOP;
            S_STOP:   if (rx_sample) rx_state_nx = S_IDLE;
            default:  rx_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rx_shift_nx = rx_shift;
        rx_tick_nx  = rx_tick_cnt;
        rx_bit_nx   = rx_bit_cnt;
        rx_done     = 1'b0;
        fe_set      = 1'b0;
        pe_set      = 1'b0;
        if (rx_state == S_IDLE) begin
            rx_tick_nx = '0;
            rx_bit_nx  = '0;
        end else if (tick) begin
            rx_tick_nx = rx_tick_cnt + 4'd1;
        end
        if (rx_bit_end && rx_state == S_DATA) rx_bit_nx = rx_bit_cnt + 3'd1;
        if (rx_sample) begin
            case (rx_state)
                S_DATA:   rx_shift_nx = {rx_s2, rx_shift[7:1]};
                S_PARITY: pe_set      = rx_s2 != (^rx_shift ^ podd_q);
                S_STOP: begin
                    rx_done = rx_s2;
                    fe_set  = ~rx_s2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hasti_uart_fifo.sv
// Directed self-checking bench for hasti_uart_fifo with a byte scoreboard queue.
module tb_hasti_uart_fifo;
    import hasti_uart_fifo_pkg::*;

    localparam int unsigned BT = 16;          // clocks per bit at div=0
    localparam logic [31:0] A_BAUD = 32'h0, A_STATUS = 32'h4, A_DATA = 32'h8, A_CTRL = 32'hC;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [2:0]  size = 3'd2;
    logic [2:0]  burst = '0;
    logic        mastlock = 1'b0;
    logic [3:0]  prot = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready, resp, irq, rxd, txd;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;

    int vectors = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rxd_drv;

    hasti_uart_fifo #(.FIFO_DEPTH(16), .RESET_DIV(16'd0)) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .read(read), .write(write),
        .size(size), .burst(burst), .mastlock(mastlock), .prot(prot),
        .wdata(wdata), .rdata(rdata), .ready(ready), .resp(resp), .irq(irq),
        .RXD(rxd), .TXD(txd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); addr = a; write = 1'b1;
        @(negedge clk); write = 1'b0; wdata = d;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); addr = a; read = 1'b1;
        @(negedge clk); read = 1'b0; d = rdata;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic expect_data(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        bus_read(A_DATA, d);
        e = (exp_q.size() == 0) ? 8'h00 : exp_q.pop_front();
        check(tag, d, {24'd0, e});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic with_par,
                              input logic par, input logic stop);
        @(negedge clk); rxd_drv = 1'b0; repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i]; repeat (BT) @(negedge clk);
        end
        if (with_par) begin
            rxd_drv = par; repeat (BT) @(negedge clk);
        end
        rxd_drv = stop; repeat (BT) @(negedge clk);
        rxd_drv = 1'b1; repeat (2*BT) @(negedge clk);
    endtask

    initial begin
        logic [31:0] s;
        logic [9:0]  frame;
        logic [7:0]  b;
        int          n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        resetn = 1'b1;
        check_reg("rst_baud", A_BAUD, 32'h0);
        check_reg("rst_status", A_STATUS, 32'h09);
        check_reg("rst_ctrl", A_CTRL, 32'h0);
        check("rst_txd_after", 32'(txd), 32'd1);
        check("ready", 32'(ready), 32'd1);
        check("resp", 32'(resp), 32'd0);

        // Transmit 0xA5 at div=0: 16 clocks per bit
        bus_write(A_DATA, 32'hA5);
        n = 0;
        while (txd !== 1'b0 && n < 8) begin @(negedge clk); n++; end
        check("tx_start_seen", 32'(txd), 32'd0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int c = 0; c < 160; c++) begin
            if (c % 16 == 0 || c % 16 == 15)
                check($sformatf("tx_bit%0d_c%0d", c / 16, c % 16), 32'(txd), 32'(frame[c / 16]));
            @(negedge clk);
        end
        check("tx_idle_line", 32'(txd), 32'd1);
        check_reg("tx_txidle", A_STATUS, 32'h09);

        // Loopback at div=3
        bus_write(A_BAUD, 32'h3);
        check_reg("baud_rb", A_BAUD, 32'h3);
        loop_en = 1'b1;
        bus_write(A_DATA, 32'h3C);
        exp_q.push_back(8'h3C);
        check_reg("tx_busy_status", A_STATUS, 32'h01);
        s = 32'h1; n = 0;
        while (s[0] && n < 1000) begin bus_read(A_STATUS, s); n++; end
        check("loop_rxe_clear", 32'(s[0]), 32'd0);
        expect_data("loop_data");
        bus_read(A_STATUS, s);
        check("loop_rxe_set", 32'(s[0]), 32'd1);
        repeat (100) @(negedge clk);
        loop_en = 1'b0;
        bus_write(A_BAUD, 32'h0);

        // 17 frames into a 16-deep RX FIFO
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k < 16) exp_q.push_back(b);
            send_frame(b, 1'b0, 1'b0, 1'b1);
        end
        check_reg("ovr_status", A_STATUS, 32'h1C);
        bus_write(A_STATUS, 32'h10);
        check_reg("ovr_cleared", A_STATUS, 32'h0C);
        for (int k = 0; k < 16; k++) expect_data($sformatf("ovr_data%0d", k));
        check_reg("drained_status", A_STATUS, 32'h09);
        expect_data("empty_read_zero");

        // Framing error
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check_reg("fe_status", A_STATUS, 32'h29);
        bus_write(A_STATUS, 32'h20);
        check_reg("fe_cleared", A_STATUS, 32'h09);

`ifdef UART_HASTI_PARITY_EN
        // Even parity with a wrong parity bit: PE set, byte kept
        bus_write(A_CTRL, 32'h4);
        check_reg("ctrl_pen_rb", A_CTRL, 32'h4);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check_reg("pe_status", A_STATUS, 32'h48);
        expect_data("pe_data");
        bus_write(A_STATUS, 32'h40);
        check_reg("pe_cleared", A_STATUS, 32'h09);
        bus_write(A_CTRL, 32'h0);
`else
        bus_write(A_CTRL, 32'hC);
        check_reg("ctrl_par_ignored", A_CTRL, 32'h0);
`endif

        // RX interrupt
        bus_write(A_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        check("irq_idle", 32'(irq), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("irq_rx", 32'(irq), 32'd1);
        expect_data("irq_data");
        @(negedge clk);
        check("irq_lag", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);

        // TX-idle interrupt
        bus_write(A_CTRL, 32'h2);
        repeat (2) @(negedge clk);
        check("irq_txidle", 32'(irq), 32'd1);
        bus_write(A_CTRL, 32'h0);
        repeat (2) @(negedge clk);
        check("irq_off", 32'(irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
